hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage RV32I core. Produces stall/flush controls for the F|D, D|E,
//  E|M and M|W pipeline registers, and forwarding selects for the E-stage ALU operands.

---
 rtl/hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard controller for a 5-stage RV32I pipeline. It does three jobs:
//   - Chooses the forwarding source for each E-stage ALU operand.
//   - Generates stall and flush controls for the pipeline registers.
//     The triggers are a load-use hazard, a taken branch resolved in E,
//     and a multi-cycle data-memory access in M.
//   - Keeps saturating counters of stall cycles and branch flushes.
//
// Parameters
//   MEM_LAT  extra wait cycles per memory op in M (0 = single-cycle memory)
//   CNT_W    width of the performance counters
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   Rs1D, Rs2D                source registers of the instruction in D
//   Rs1E, Rs2E                source registers of the instruction in E
//   RdE, RdM, RdW             destination registers in E / M / W
//   LoadE                     instruction in E is a load
//   RegWriteM, RegWriteW      instruction in M / W writes the register file
//   PCSrcE                    taken branch/jump resolved in E
//   MemAccessM                instruction in M is a load or store
//   StallF, StallD            hold PC / hold F|D register
//   StallE, StallM            hold D|E / E|M register
//   FlushD, FlushE, FlushW    clear F|D / D|E / M|W register
//   ForwardAE, ForwardBE      operand source: 00 RF, 01 ResultW, 10 ALUResultM
//   StallCnt, FlushCnt        saturating stall-cycle / branch-flush counters
module hazard_ctrl #(
  parameter int MEM_LAT = 0,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             LoadE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemAccessM,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int WCNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [WCNT_W-1:0] WCNT_INIT = (MEM_LAT > 0) ? WCNT_W'(MEM_LAT - 1) : '0;
  localparam bit HAS_LAT = (MEM_LAT != 0);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              lw_stall;
  logic              mem_stall;

  // M has priority over W: it holds the younger value of the register.
  // x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic we_m, input logic [4:0] rd_w,
                                         input logic we_w);
    if (we_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (we_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != '1) ? v + CNT_W'(1) : v;
  endfunction

  assign lw_stall = LoadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);

  // Memory-wait FSM. Entering WAIT with MEM_LAT-1 makes the op sit in M
  // for exactly MEM_LAT stalled cycles. The cycle where wcnt reaches 0
  // releases the pipeline.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_stall = 1'b0;
    case (state_q)
      S_RUN: begin
        mem_stall = MemAccessM && HAS_LAT;
        if (mem_stall) begin
          state_d = S_WAIT;
          wcnt_d  = WCNT_INIT;
        end
      end
      default: begin
        mem_stall = (wcnt_q != '0);
        if (mem_stall) wcnt_d = wcnt_q - WCNT_W'(1);
        else           state_d = S_RUN;
      end
    endcase
  end

  // While E is frozen by a memory stall, lwStall and PCSrcE describe a
  // stale E instruction. They are ignored until the pipeline moves again.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushW    = 1'b1;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!rst) begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b1;
      end else begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushD = PCSrcE;
        FlushE = lw_stall || PCSrcE;
        FlushW = 1'b0;
      end
    end
  end

  assign stall_cnt_d = sat_inc(stall_cnt_q, lw_stall || mem_stall);
  assign flush_cnt_d = sat_inc(flush_cnt_q, PCSrcE && !mem_stall);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  // Instance 0: MEM_LAT=0, instance 1: MEM_LAT=2, instance 2: MEM_LAT=3.
  // All three use CNT_W=4 and share the same stimulus.
  localparam int LAT [3] = '{0, 2, 3};

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       LoadE, RegWriteM, RegWriteW, PCSrcE, MemAccessM;

  logic       StallF [3];
  logic       StallD [3];
  logic       FlushD [3];
  logic       FlushE [3];
  logic       StallE [3];
  logic       StallM [3];
  logic       FlushW [3];
  logic [1:0] FwdA   [3];
  logic [1:0] FwdB   [3];
  logic [3:0] SCnt   [3];
  logic [3:0] FCnt   [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl #(.MEM_LAT(LAT[g]), .CNT_W(4)) u_dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .LoadE(LoadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .PCSrcE(PCSrcE), .MemAccessM(MemAccessM),
      .StallF(StallF[g]), .StallD(StallD[g]), .FlushD(FlushD[g]), .FlushE(FlushE[g]),
      .StallE(StallE[g]), .StallM(StallM[g]), .FlushW(FlushW[g]),
      .ForwardAE(FwdA[g]), .ForwardBE(FwdB[g]),
      .StallCnt(SCnt[g]), .FlushCnt(FCnt[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    LoadE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    PCSrcE = 1'b0; MemAccessM = 1'b0;
  endtask

  // Advance one clock; inputs are changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;

    // 1: reset forces flushes, no stalls; afterwards RUN with zero counters
    check("rst_FlushD", 32'(FlushD[0]), 32'd1);
    check("rst_FlushE", 32'(FlushE[0]), 32'd1);
    check("rst_FlushW", 32'(FlushW[0]), 32'd1);
    check("rst_StallF", 32'(StallF[0]), 32'd0);
    check("rst_StallM", 32'(StallM[1]), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_StallCnt", 32'(SCnt[0]), 32'd0);
    check("post_rst_FlushCnt", 32'(FCnt[0]), 32'd0);
    check("post_rst_FlushW", 32'(FlushW[0]), 32'd0);
    check("post_rst_StallM", 32'(StallM[1]), 32'd0);

    // 2: forwarding priority and x0
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd9;
    #1;
    check("fwdA_M", 32'(FwdA[0]), 32'd2);
    check("fwdB_none", 32'(FwdB[0]), 32'd0);
    RegWriteM = 1'b0;
    #1;
    check("fwdA_W", 32'(FwdA[0]), 32'd1);
    Rs1E = 5'd0; RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1;
    #1;
    check("fwdA_x0", 32'(FwdA[0]), 32'd0);
    Rs2E = 5'd9; RdW = 5'd9;
    #1;
    check("fwdB_W", 32'(FwdB[0]), 32'd1);
    idle_inputs();

    // 3: load-use stall for one cycle
    do_reset();
    LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    check("lw_StallF", 32'(StallF[0]), 32'd1);
    check("lw_StallD", 32'(StallD[0]), 32'd1);
    check("lw_FlushE", 32'(FlushE[0]), 32'd1);
    check("lw_FlushD", 32'(FlushD[0]), 32'd0);
    tick();
    LoadE = 1'b0; RdE = 5'd0;
    #1;
    check("lw_StallCnt", 32'(SCnt[0]), 32'd1);
    check("lw_released", 32'(StallF[0]), 32'd0);
    LoadE = 1'b1; RdE = 5'd0; Rs2D = 5'd0;
    #1;
    check("lw_x0_StallF", 32'(StallF[0]), 32'd0);
    check("lw_x0_FlushE", 32'(FlushE[0]), 32'd0);
    idle_inputs();

    // 4: MEM_LAT=2 -> exactly two stall cycles; branch waits for release
    do_reset();
    MemAccessM = 1'b1;
    #1;
    check("mem2_c1_StallM", 32'(StallM[1]), 32'd1);
    check("mem2_c1_FlushW", 32'(FlushW[1]), 32'd1);
    check("mem0_c1_StallM", 32'(StallM[0]), 32'd0);
    tick();
    PCSrcE = 1'b1;
    #1;
    check("mem2_c2_StallM", 32'(StallM[1]), 32'd1);
    check("mem2_c2_FlushD", 32'(FlushD[1]), 32'd0);
    check("mem2_c2_FlushE", 32'(FlushE[1]), 32'd0);
    tick();
    #1;
    check("mem2_c3_StallM", 32'(StallM[1]), 32'd0);
    check("mem2_c3_FlushW", 32'(FlushW[1]), 32'd0);
    check("mem2_c3_FlushD", 32'(FlushD[1]), 32'd1);
    check("mem2_c3_FlushE", 32'(FlushE[1]), 32'd1);
    tick();
    MemAccessM = 1'b0; PCSrcE = 1'b0;
    #1;
    check("mem2_run_StallM", 32'(StallM[1]), 32'd0);
    check("mem2_FlushCnt", 32'(FCnt[1]), 32'd1);
    check("mem2_StallCnt", 32'(SCnt[1]), 32'd2);
    idle_inputs();

    // 5: MEM_LAT=3, reset in the second wait cycle aborts the wait
    do_reset();
    MemAccessM = 1'b1;
    #1;
    check("mem3_c1_StallM", 32'(StallM[2]), 32'd1);
    tick();
    #1;
    check("mem3_c2_StallM", 32'(StallM[2]), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    check("mem3_rst_StallM", 32'(StallM[2]), 32'd0);
    check("mem3_rst_FlushW", 32'(FlushW[2]), 32'd1);
    tick();
    rst = 1'b0; MemAccessM = 1'b0;
    #1;
    check("mem3_after_StallM", 32'(StallM[2]), 32'd0);
    check("mem3_after_StallF", 32'(StallF[2]), 32'd0);
    check("mem3_after_StallCnt", 32'(SCnt[2]), 32'd0);
    check("mem3_after_FlushCnt", 32'(FCnt[2]), 32'd0);
    idle_inputs();

    // 6: 20 load-use stall cycles saturate a 4-bit counter at 15
    do_reset();
    LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
    for (int i = 0; i < 14; i++) tick();
    #1;
    check("sat_14", 32'(SCnt[0]), 32'd14);
    for (int i = 0; i < 6; i++) tick();
    #1;
    check("sat_20", 32'(SCnt[0]), 32'd15);
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
